// File: rtl/cache_writeback_buffer_pkg.sv
// Shared definitions for the cache write-back buffer: default widths and FSM encoding.
package cache_writeback_buffer_pkg;

    localparam int TAG_WIDTH_DEF   = 2;
    localparam int VALUE_WIDTH_DEF = 32;
    localparam int DEPTH_DEF       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } wb_state_e;

endpackage

// File: rtl/cache_writeback_buffer_wb_fifo.sv
// Eviction FIFO: tag/value storage, push/pop bookkeeping and a newest-first tag search.
module wb_fifo
    import cache_writeback_buffer_pkg::*;
#(
    parameter int TAG_WIDTH   = TAG_WIDTH_DEF,
    parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [TAG_WIDTH-1:0]   push_tag,
    input  logic [VALUE_WIDTH-1:0] push_value,
    input  logic                   pop,
    output logic [TAG_WIDTH-1:0]   head_tag,
    output logic [VALUE_WIDTH-1:0] head_value,
    output logic                   full,
    output logic                   empty,
    output logic                   push_drop,
    input  logic [TAG_WIDTH-1:0]   search_tag,
    output logic                   hit,
    output logic [VALUE_WIDTH-1:0] hit_value
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [TAG_WIDTH-1:0]   tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]   tag_d [DEPTH];
    logic [VALUE_WIDTH-1:0] val_q [DEPTH];
    logic [VALUE_WIDTH-1:0] val_d [DEPTH];
    logic                   pop_ok;
    logic                   push_ok;
    logic [PTR_W-1:0]       idx;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign pop_ok     = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push && (!full || pop_ok);
    assign push_drop  = push && !push_ok;
    assign head_tag   = tag_q[rd_ptr_q];
    assign head_value = val_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        tag_d    = tag_q;
        val_d    = val_q;
        if (pop_ok) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            vld_d[wr_ptr_q] = 1'b1;
            tag_d[wr_ptr_q] = push_tag;
            val_d[wr_ptr_q] = push_value;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to newest so the last match seen is the newest one.
    always_comb begin
        hit       = 1'b0;
        hit_value = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (vld_q[idx] && (tag_q[idx] == search_tag)) begin
                hit       = 1'b1;
                hit_value = val_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        val_q <= val_d;
    end

endmodule

// File: rtl/cache_writeback_buffer.sv
// Memory-side write-back buffer: queues dirty evictions, drains them to memory and serves refills.
module cache_writeback_buffer
    import cache_writeback_buffer_pkg::*;
#(
    parameter int TAG_WIDTH   = TAG_WIDTH_DEF,
    parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   evict_valid,
    input  logic [TAG_WIDTH-1:0]   evict_tag,
    input  logic [VALUE_WIDTH-1:0] evict_value,
    output logic                   buf_full,
    output logic                   buf_empty,
    output logic                   overflow,
    input  logic                   fill_req_,
    input  logic [TAG_WIDTH-1:0]   fill_tag,
    output logic                   fill_ready,
    output logic [VALUE_WIDTH-1:0] fill_value,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [TAG_WIDTH-1:0]   mem_tag,
    output logic [VALUE_WIDTH-1:0] mem_wdata,
    input  logic [VALUE_WIDTH-1:0] mem_rdata,
    input  logic                   mem_ack
);

    wb_state_e              state_q, state_d;
    logic                   overflow_q, overflow_d;
    logic                   fill_ready_q, fill_ready_d;
    logic [VALUE_WIDTH-1:0] fill_value_q, fill_value_d;
    logic [VALUE_WIDTH-1:0] fwd_value_q, fwd_value_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [TAG_WIDTH-1:0]   mem_tag_q, mem_tag_d;
    logic [VALUE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push_drop;
    logic                   fifo_hit;
    logic [VALUE_WIDTH-1:0] fifo_hit_value;
    logic [TAG_WIDTH-1:0]   head_tag;
    logic [VALUE_WIDTH-1:0] head_value;
    logic                   bypass_hit;
    logic                   match_hit;
    logic [VALUE_WIDTH-1:0] match_value;
    logic                   fill_pending;

    wb_fifo #(
        .TAG_WIDTH   (TAG_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (evict_valid),
        .push_tag   (evict_tag),
        .push_value (evict_value),
        .pop        (fifo_pop),
        .head_tag   (head_tag),
        .head_value (head_value),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .push_drop  (push_drop),
        .search_tag (fill_tag),
        .hit        (fifo_hit),
        .hit_value  (fifo_hit_value)
    );

    // An eviction arriving this cycle is newer than anything already queued.
    assign bypass_hit  = evict_valid && (evict_tag == fill_tag);
    assign match_hit   = bypass_hit || fifo_hit;
    assign match_value = bypass_hit ? evict_value : fifo_hit_value;
    // The requester still holds fill_req_ low during the fill_ready cycle; do not restart then.
    assign fill_pending = !fill_req_ && !fill_ready_q;

    always_comb begin
        state_d      = state_q;
        overflow_d   = overflow_q | push_drop;
        fill_ready_d = 1'b0;
        fill_value_d = fill_value_q;
        fwd_value_d  = fwd_value_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_tag_d    = mem_tag_q;
        mem_wdata_d  = mem_wdata_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_pending) begin
                    if (match_hit) begin
                        state_d     = ST_FWD;
                        fwd_value_d = match_value;
                    end else begin
                        state_d   = ST_READ;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_tag_d = fill_tag;
                    end
                end else if (fill_req_ && !fifo_empty) begin
                    state_d     = ST_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_tag_d   = head_tag;
                    mem_wdata_d = head_value;
                end
            end
            ST_FWD: begin
                state_d      = ST_IDLE;
                fill_ready_d = 1'b1;
                fill_value_d = bypass_hit ? evict_value : fwd_value_q;
            end
            ST_READ: begin
                if (mem_ack) begin
                    state_d      = ST_IDLE;
                    mem_req_d    = 1'b0;
                    fill_ready_d = 1'b1;
                    fill_value_d = mem_rdata;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    fifo_pop  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            overflow_q   <= 1'b0;
            fill_ready_q <= 1'b0;
            fill_value_q <= '0;
            fwd_value_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_tag_q    <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            overflow_q   <= overflow_d;
            fill_ready_q <= fill_ready_d;
            fill_value_q <= fill_value_d;
            fwd_value_q  <= fwd_value_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_tag_q    <= mem_tag_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign buf_full   = fifo_full;
    assign buf_empty  = fifo_empty;
    assign overflow   = overflow_q;
    assign fill_ready = fill_ready_q;
    assign fill_value = fill_value_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_tag    = mem_tag_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
